// File: rtl/lpc_reg_rd_mux.sv
// rtl/lpc_reg_rd_mux.sv - parametrised LPC register read mux with handshake, clear-on-read and snapshot
module lpc_reg_rd_mux #(
  parameter int                  NUM_REGS     = 32,
  parameter int                  DATA_W       = 8,
  parameter int                  ADDR_W       = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR    = '0,
  parameter int                  LATENCY      = 1,
  parameter logic [DATA_W-1:0]   DEFAULT_DATA = '0,
  parameter logic [NUM_REGS-1:0] CLR_MASK     = '0,
  parameter bit                  SNAP_EN      = 1'b0,
  parameter int                  SNAP_IDX     = 0,
  parameter int                  SNAP_LEN     = 2
) (
  input  logic                       LpcClock,
  input  logic                       PciReset,
  input  logic [ADDR_W-1:0]          AddrReg,
  input  logic                       RdReq,
  input  logic [NUM_REGS*DATA_W-1:0] RegBus,
  output logic [DATA_W-1:0]          DataRd,
  output logic                       RdAck,
  output logic                       Hit,
  output logic [NUM_REGS-1:0]        RdClr,
  output logic                       SnapValid
);

  localparam int IW    = ADDR_W + 1;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BUF_N = SNAP_LEN - 1;

  // Request-side decode
  logic [IW-1:0]    req_idx;
  logic             req_in;

  // Optional first pipeline stage (used only when LATENCY == 2)
  logic             s1_valid;
  logic [SEL_W-1:0] s1_sel;
  logic             s1_in;

  // Inputs to the data-sampling (final) edge
  logic             fin_valid;
  logic [SEL_W-1:0] fin_sel;
  logic             fin_in;

  logic [DATA_W-1:0]   reg_arr [NUM_REGS];
  logic [DATA_W-1:0]   snap_buf [BUF_N];
  logic [DATA_W-1:0]   rd_val;
  logic [NUM_REGS-1:0] clr_vec;
  logic                is_snap_lo;
  logic                is_snap_hi;

  // Offset the address by the base and flag whether it lands inside the register file
  always_comb begin
    req_idx = {1'b0, AddrReg} - {1'b0, BASE_ADDR};
    req_in  = (AddrReg >= BASE_ADDR) && (int'(req_idx) < NUM_REGS);
  end

  // Latency-2 address stage: holds the decoded request for one cycle
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_in    <= 1'b0;
    end else begin
      s1_valid <= RdReq;
      s1_sel   <= req_idx[SEL_W-1:0];
      s1_in    <= req_in;
    end
  end

  assign fin_valid = (LATENCY == 2) ? s1_valid : RdReq;
  assign fin_sel   = (LATENCY == 2) ? s1_sel   : req_idx[SEL_W-1:0];
  assign fin_in    = (LATENCY == 2) ? s1_in    : req_in;

  // Unflatten the register bus for indexed access
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_arr[i] = RegBus[i*DATA_W +: DATA_W];
    end
  end

  // Select read data: live register, buffered snapshot word, or default for misses
  always_comb begin
    rd_val = reg_arr[fin_sel];
    if (SNAP_EN && SnapValid) begin
      for (int k = 1; k < SNAP_LEN; k++) begin
        if (int'(fin_sel) == SNAP_IDX + k) rd_val = snap_buf[k-1];
      end
    end
    if (!fin_in) rd_val = DEFAULT_DATA;
  end

  // One-hot clear strobe for clear-on-read registers, plus snapshot group decode
  always_comb begin
    clr_vec = '0;
    if (fin_in && CLR_MASK[fin_sel]) clr_vec[fin_sel] = 1'b1;
    is_snap_lo = SNAP_EN && fin_in && (int'(fin_sel) == SNAP_IDX);
    is_snap_hi = SNAP_EN && fin_in && (int'(fin_sel) == SNAP_IDX + SNAP_LEN - 1);
  end

  // Output stage: registers the acknowledge, data, hit and clear strobe at the sampling edge
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      DataRd <= '0;
      RdAck  <= 1'b0;
      Hit    <= 1'b0;
      RdClr  <= '0;
    end else if (fin_valid) begin
      DataRd <= rd_val;
      RdAck  <= 1'b1;
      Hit    <= fin_in;
      RdClr  <= clr_vec;
    end else begin
      RdAck  <= 1'b0;
      Hit    <= 1'b0;
      RdClr  <= '0;
    end
  end

  // Snapshot buffer: reading the low word freezes the upper words; reading the top word releases them.
  // The modulo keeps the constant capture index legal when the snapshot group is disabled.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      SnapValid <= 1'b0;
      for (int k = 0; k < BUF_N; k++) snap_buf[k] <= '0;
    end else if (fin_valid) begin
      if (is_snap_lo) begin
        SnapValid <= 1'b1;
        for (int k = 1; k < SNAP_LEN; k++) begin
          snap_buf[k-1] <= reg_arr[(SNAP_IDX + k) % NUM_REGS];
        end
      end else if (is_snap_hi) begin
        SnapValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpc_reg_rd_mux.sv
// tb/tb_lpc_reg_rd_mux.sv - self-checking bench for lpc_reg_rd_mux (two configurations)
module tb_lpc_reg_rd_mux;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: 8 regs at base 0x10, latency 1, clear-on-read idx 3, snapshot 4..6
  logic [7:0]  a_addr;
  logic        a_req;
  logic [63:0] a_bus;
  logic [7:0]  a_data;
  logic        a_ack, a_hit, a_snapv;
  logic [7:0]  a_clr;
  logic [7:0]  regs_a [8];

  // Instance B: 32 regs at base 0, latency 2, clear-on-read idx 3
  logic [7:0]   b_addr;
  logic         b_req;
  logic [255:0] b_bus;
  logic [7:0]   b_data;
  logic         b_ack, b_hit, b_snapv;
  logic [31:0]  b_clr;
  logic [7:0]   regs_b [32];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       ma_snapv;
  logic [7:0] ma_buf [2];
  logic [7:0] ma_last;
  logic [7:0] mb_last;

  always #15 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) a_bus[i*8 +: 8] = regs_a[i];
    for (int i = 0; i < 32; i++) b_bus[i*8 +: 8] = regs_b[i];
  end

  lpc_reg_rd_mux #(
    .NUM_REGS(8), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'h10), .LATENCY(1),
    .DEFAULT_DATA(8'hFF), .CLR_MASK(8'h08), .SNAP_EN(1'b1), .SNAP_IDX(4), .SNAP_LEN(3)
  ) dut_a (
    .LpcClock(clk), .PciReset(rst_n), .AddrReg(a_addr), .RdReq(a_req), .RegBus(a_bus),
    .DataRd(a_data), .RdAck(a_ack), .Hit(a_hit), .RdClr(a_clr), .SnapValid(a_snapv)
  );

  lpc_reg_rd_mux #(
    .NUM_REGS(32), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'h00), .LATENCY(2),
    .DEFAULT_DATA(8'h00), .CLR_MASK(32'h0000_0008), .SNAP_EN(1'b0), .SNAP_IDX(0), .SNAP_LEN(2)
  ) dut_b (
    .LpcClock(clk), .PciReset(rst_n), .AddrReg(b_addr), .RdReq(b_req), .RegBus(b_bus),
    .DataRd(b_data), .RdAck(b_ack), .Hit(b_hit), .RdClr(b_clr), .SnapValid(b_snapv)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of instance A: range check by subtraction, snapshot as a frozen copy
  task automatic model_a(input logic [7:0] addr, output logic [7:0] d, output logic h, output logic [7:0] c);
    int idx;
    idx = int'(addr) - 16;
    h = (idx >= 0) && (idx < 8);
    d = 8'hFF;
    c = 8'h00;
    if (h) begin
      d = regs_a[idx];
      if (ma_snapv && (idx == 5 || idx == 6)) d = ma_buf[idx-5];
      if (idx == 3) c = 8'h08;
      if (idx == 4) begin
        ma_buf[0] = regs_a[5];
        ma_buf[1] = regs_a[6];
        ma_snapv  = 1'b1;
      end else if (idx == 6) begin
        ma_snapv = 1'b0;
      end
    end
    ma_last = d;
  endtask

  task automatic model_b(input logic [7:0] addr, output logic [7:0] d, output logic h, output logic [31:0] c);
    h = (int'(addr) < 32);
    d = h ? regs_b[addr[4:0]] : 8'h00;
    c = (h && addr == 8'd3) ? 32'h0000_0008 : 32'h0;
    mb_last = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_addr = '0;
    for (int i = 0; i < 8; i++) regs_a[i] = '0;
    for (int i = 0; i < 32; i++) regs_b[i] = '0;
    tick; tick;
    n_tests++; if (a_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_data got %h exp 00", a_data); end
    n_tests++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL reset_a_ack got %b exp 0", a_ack); end
    n_tests++; if (a_hit !== 1'b0) begin n_fail++; $display("FAIL reset_a_hit got %b exp 0", a_hit); end
    n_tests++; if (a_clr !== 8'h00) begin n_fail++; $display("FAIL reset_a_clr got %h exp 00", a_clr); end
    n_tests++; if (a_snapv !== 1'b0) begin n_fail++; $display("FAIL reset_a_snapv got %b exp 0", a_snapv); end
    n_tests++; if (b_data !== 8'h00 || b_ack !== 1'b0 || b_hit !== 1'b0 || b_clr !== 32'h0)
      begin n_fail++; $display("FAIL reset_b got data=%h ack=%b hit=%b clr=%h exp all 0", b_data, b_ack, b_hit, b_clr); end
    rst_n = 1'b1;
    tick;
    n_tests++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ack got a=%b b=%b exp 0", a_ack, b_ack); end
  endtask

  task automatic test_basic;
    regs_a[2] = 8'h5A;
    a_addr = 8'h12; a_req = 1'b1;
    tick;
    a_req = 1'b0;
    n_tests++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack got %b exp 1", a_ack); end
    n_tests++; if (a_hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit got %b exp 1", a_hit); end
    n_tests++; if (a_data !== 8'h5A) begin n_fail++; $display("FAIL basic_data got %h exp 5a", a_data); end
    n_tests++; if (a_clr !== 8'h00) begin n_fail++; $display("FAIL basic_clr got %h exp 00", a_clr); end
    tick;
    n_tests++; if (a_ack !== 1'b0 || a_hit !== 1'b0) begin n_fail++; $display("FAIL basic_idle got ack=%b hit=%b exp 0 0", a_ack, a_hit); end
    n_tests++; if (a_data !== 8'h5A) begin n_fail++; $display("FAIL basic_hold got %h exp 5a", a_data); end
  endtask

  task automatic test_out_of_range;
    logic [7:0] addrs [3];
    logic [7:0] exp_d [3];
    logic       exp_h [3];
    addrs[0] = 8'h0F; exp_d[0] = 8'hFF; exp_h[0] = 1'b0;
    addrs[1] = 8'h18; exp_d[1] = 8'hFF; exp_h[1] = 1'b0;
    addrs[2] = 8'h17; exp_d[2] = 8'h77; exp_h[2] = 1'b1;
    regs_a[7] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      a_addr = addrs[i]; a_req = 1'b1;
      tick;
      n_tests++; if (a_ack !== 1'b1 || a_hit !== exp_h[i] || a_data !== exp_d[i] || a_clr !== 8'h00)
        begin n_fail++; $display("FAIL oor_%h got ack=%b hit=%b data=%h clr=%h exp 1 %b %h 00",
                                 addrs[i], a_ack, a_hit, a_data, a_clr, exp_h[i], exp_d[i]); end
    end
    a_req = 1'b0;
    tick;
  endtask

  task automatic test_clear_on_read;
    regs_b[3] = 8'h80; regs_b[4] = 8'h44;
    b_addr = 8'd3; b_req = 1'b1;
    tick;
    b_req = 1'b0;
    n_tests++; if (b_ack !== 1'b0 || b_clr !== 32'h0) begin n_fail++; $display("FAIL clr_early got ack=%b clr=%h exp 0 0", b_ack, b_clr); end
    tick;
    n_tests++; if (b_ack !== 1'b1 || b_data !== 8'h80 || b_hit !== 1'b1)
      begin n_fail++; $display("FAIL clr_read3 got ack=%b data=%h hit=%b exp 1 80 1", b_ack, b_data, b_hit); end
    n_tests++; if (b_clr !== 32'h0000_0008) begin n_fail++; $display("FAIL clr_strobe got %h exp 00000008", b_clr); end
    tick;
    n_tests++; if (b_clr !== 32'h0 || b_ack !== 1'b0 || b_data !== 8'h80)
      begin n_fail++; $display("FAIL clr_after got clr=%h ack=%b data=%h exp 0 0 80", b_clr, b_ack, b_data); end
    b_addr = 8'd4; b_req = 1'b1;
    tick;
    b_req = 1'b0;
    tick;
    n_tests++; if (b_ack !== 1'b1 || b_data !== 8'h44 || b_clr !== 32'h0)
      begin n_fail++; $display("FAIL clr_read4 got ack=%b data=%h clr=%h exp 1 44 0", b_ack, b_data, b_clr); end
    regs_a[3] = 8'h3C;
    a_addr = 8'h13; a_req = 1'b1;
    tick;
    a_req = 1'b0;
    n_tests++; if (a_clr !== 8'h08 || a_data !== 8'h3C) begin n_fail++; $display("FAIL clr_a got clr=%h data=%h exp 08 3c", a_clr, a_data); end
    tick;
  endtask

  task automatic test_snapshot;
    logic [7:0] rd_addr [4];
    logic [7:0] exp_d   [4];
    logic       exp_v   [4];
    rd_addr[0] = 8'h14; exp_d[0] = 8'h11; exp_v[0] = 1'b1;
    rd_addr[1] = 8'h15; exp_d[1] = 8'h22; exp_v[1] = 1'b1;
    rd_addr[2] = 8'h16; exp_d[2] = 8'h33; exp_v[2] = 1'b0;
    rd_addr[3] = 8'h15; exp_d[3] = 8'hAA; exp_v[3] = 1'b0;
    regs_a[4] = 8'h11; regs_a[5] = 8'h22; regs_a[6] = 8'h33;
    for (int i = 0; i < 4; i++) begin
      a_addr = rd_addr[i]; a_req = 1'b1;
      tick;
      a_req = 1'b0;
      n_tests++; if (a_ack !== 1'b1 || a_data !== exp_d[i] || a_snapv !== exp_v[i] || a_clr !== 8'h00)
        begin n_fail++; $display("FAIL snap_step%0d got ack=%b data=%h snapv=%b clr=%h exp 1 %h %b 00",
                                 i, a_ack, a_data, a_snapv, a_clr, exp_d[i], exp_v[i]); end
      if (i == 0) begin regs_a[5] = 8'hAA; regs_a[6] = 8'hBB; end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) regs_b[i] = 8'($urandom);
    b_addr = 8'd0; b_req = 1'b1;
    tick;
    n_tests++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_c1 got ack=%b exp 0", b_ack); end
    b_addr = 8'd1;
    tick;
    n_tests++; if (b_ack !== 1'b1 || b_data !== regs_b[0]) begin n_fail++; $display("FAIL b2b_c2 got ack=%b data=%h exp 1 %h", b_ack, b_data, regs_b[0]); end
    b_addr = 8'd2;
    tick;
    b_req = 1'b0;
    n_tests++; if (b_ack !== 1'b1 || b_data !== regs_b[1]) begin n_fail++; $display("FAIL b2b_c3 got ack=%b data=%h exp 1 %h", b_ack, b_data, regs_b[1]); end
    tick;
    n_tests++; if (b_ack !== 1'b1 || b_data !== regs_b[2]) begin n_fail++; $display("FAIL b2b_c4 got ack=%b data=%h exp 1 %h", b_ack, b_data, regs_b[2]); end
    tick;
    n_tests++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_c5 got ack=%b exp 0", b_ack); end
  endtask

  task automatic test_reset_mid;
    regs_b[5] = 8'h55; regs_b[6] = 8'h66;
    b_addr = 8'd5; b_req = 1'b1;
    tick;
    b_addr = 8'd6;
    tick;
    b_req = 1'b0;
    n_tests++; if (b_ack !== 1'b1 || b_data !== 8'h55) begin n_fail++; $display("FAIL rstmid_ack0 got ack=%b data=%h exp 1 55", b_ack, b_data); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (b_ack !== 1'b0 || b_data !== 8'h00 || b_hit !== 1'b0 || b_clr !== 32'h0 || a_snapv !== 1'b0 || a_data !== 8'h00)
      begin n_fail++; $display("FAIL rstmid_async got b_ack=%b b_data=%h b_hit=%b b_clr=%h a_snapv=%b a_data=%h exp all 0",
                               b_ack, b_data, b_hit, b_clr, a_snapv, a_data); end
    tick;
    rst_n = 1'b1;
    ma_snapv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++; if (b_ack !== 1'b0 || b_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_noack%0d got ack=%b data=%h exp 0 00", i, b_ack, b_data); end
    end
  endtask

  task automatic test_random_a;
    logic [7:0] ed, ec, addr;
    logic       eh, req, have_last;
    have_last = 1'b0;
    ma_snapv  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(2) == 0) regs_a[$urandom_range(7)] = 8'($urandom);
      req  = 1'($urandom_range(1));
      addr = 8'($urandom_range(8'h1B, 8'h0C));
      a_addr = addr; a_req = req;
      if (req) model_a(addr, ed, eh, ec);
      tick;
      n_tests++; if (a_ack !== req) begin n_fail++; $display("FAIL rnd_a_ack n=%0d got %b exp %b", n, a_ack, req); end
      if (req) begin
        have_last = 1'b1;
        n_tests++; if (a_data !== ed || a_hit !== eh || a_clr !== ec)
          begin n_fail++; $display("FAIL rnd_a_read n=%0d addr=%h got data=%h hit=%b clr=%h exp %h %b %h",
                                   n, addr, a_data, a_hit, a_clr, ed, eh, ec); end
      end else begin
        n_tests++; if (a_hit !== 1'b0 || a_clr !== 8'h00) begin n_fail++; $display("FAIL rnd_a_idle n=%0d got hit=%b clr=%h exp 0 00", n, a_hit, a_clr); end
        if (have_last) begin
          n_tests++; if (a_data !== ma_last) begin n_fail++; $display("FAIL rnd_a_hold n=%0d got %h exp %h", n, a_data, ma_last); end
        end
      end
      n_tests++; if (a_snapv !== ma_snapv) begin n_fail++; $display("FAIL rnd_a_snapv n=%0d got %b exp %b", n, a_snapv, ma_snapv); end
    end
    a_req = 1'b0;
    tick;
  endtask

  task automatic test_random_b;
    logic [7:0]  ed, addr, pend_addr;
    logic [31:0] ec;
    logic        eh, req, pend_v, have_last;
    pend_v = 1'b0; pend_addr = '0; have_last = 1'b0;
    ed = '0; eh = 1'b0; ec = '0;
    for (int n = 0; n < 302; n++) begin
      if ($urandom_range(2) == 0) regs_b[$urandom_range(31)] = 8'($urandom);
      req  = (n < 300) ? 1'($urandom_range(1)) : 1'b0;
      addr = 8'($urandom_range(40));
      if (pend_v) model_b(pend_addr, ed, eh, ec);
      b_addr = addr; b_req = req;
      tick;
      n_tests++; if (b_ack !== pend_v) begin n_fail++; $display("FAIL rnd_b_ack n=%0d got %b exp %b", n, b_ack, pend_v); end
      if (pend_v) begin
        have_last = 1'b1;
        n_tests++; if (b_data !== ed || b_hit !== eh || b_clr !== ec)
          begin n_fail++; $display("FAIL rnd_b_read n=%0d addr=%h got data=%h hit=%b clr=%h exp %h %b %h",
                                   n, pend_addr, b_data, b_hit, b_clr, ed, eh, ec); end
      end else if (have_last) begin
        n_tests++; if (b_data !== mb_last || b_hit !== 1'b0) begin n_fail++; $display("FAIL rnd_b_hold n=%0d got data=%h hit=%b exp %h 0", n, b_data, b_hit, mb_last); end
      end
      pend_v = req; pend_addr = addr;
    end
    b_req = 1'b0;
  endtask

  initial begin
    #(30 * 20000);
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    ma_snapv = 1'b0; ma_last = '0; mb_last = '0;
    ma_buf[0] = '0; ma_buf[1] = '0;
    test_reset;
    test_basic;
    test_out_of_range;
    test_clear_on_read;
    test_snapshot;
    test_back_to_back;
    test_reset_mid;
    test_random_a;
    test_random_b;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_reg_rd_mux.md
Name: lpc_reg_rd_mux

Overview:
- Parametrised read-data multiplexer for the LPC CPLD internal register file, generalising the fixed 32 x 8-bit read mux.
- Adds configurable register count, width and base address, and a request/acknowledge read handshake with 1- or 2-cycle latency.
- Adds per-register clear-on-read strobes and an atomic snapshot of one multi-byte counter group.
- Sits between the LPC cycle decoder (address/request side) and the register file (flattened data, clear strobes).

Parameters:
- NUM_REGS, 32, number of registers, range 1..256.
- DATA_W, 8, register width in bits.
- ADDR_W, 8, width of AddrReg.
- BASE_ADDR, 0, address of register index 0.
- LATENCY, 1, RdReq-to-RdAck latency in cycles; only 1 or 2 are legal.
- DEFAULT_DATA, 0, data returned for out-of-range reads.
- CLR_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i clear-on-read.
- SNAP_EN, 0, 1 enables the snapshot group.
- SNAP_IDX, 0, index of the snapshot group low register.
- SNAP_LEN, 2, registers in the snapshot group, range 2..4; requires SNAP_IDX+SNAP_LEN<=NUM_REGS.

Ports:
- LpcClock  in  1  33 MHz LPC clock; all state on its rising edge.
- PciReset  in  1  asynchronous, active-low reset.
- AddrReg  in  ADDR_W  read address, valid while RdReq=1.
- RdReq  in  1  single-cycle read request; may be asserted every cycle.
- RegBus  in  NUM_REGS*DATA_W  flattened register file; register i occupies bits [i*DATA_W +: DATA_W].
- DataRd  out  DATA_W  read data, valid when RdAck=1, held otherwise.
- RdAck  out  1  one-cycle acknowledge, one per request, in order.
- Hit  out  1  qualifies RdAck: 1 = address in range.
- RdClr  out  NUM_REGS  one-hot clear strobe to the register file, coincident with RdAck.
- SnapValid  out  1  snapshot buffer holds live data.

Behaviour:
- Reset (PciReset=0, asynchronous):
  - DataRd=0, RdAck=0, Hit=0, RdClr=0, SnapValid=0, snapshot buffer=0.
  - Pipeline is emptied; a request in flight is discarded and never acknowledged.
  - Outputs stay in reset state until the first edge after release.
- Decode:
  - idx = AddrReg - BASE_ADDR, computed to ADDR_W+1 bits.
  - In range iff AddrReg >= BASE_ADDR and idx < NUM_REGS.
  - Out of range: DataRd=DEFAULT_DATA, Hit=0, RdClr=0, no snapshot effect, RdAck still asserted.
- LATENCY=1:
  - At the edge sampling RdReq=1, RegBus and idx are sampled and DataRd, Hit, RdAck and RdClr are registered.
  - RdAck is high exactly the following cycle.
- LATENCY=2:
  - Edge 1 registers idx, in-range flag and a valid bit.
  - Edge 2 samples RegBus and drives the outputs; RdAck is high during cycle 2 after the request.
  - Back-to-back requests give back-to-back acks.
- Data-sampling edge: the edge that drives the outputs (the final edge in both latencies).
- Clear-on-read:
  - For an in-range read of idx with CLR_MASK[idx]=1, RdClr[idx]=1 for exactly the RdAck cycle.
  - DataRd returns the pre-clear value.
  - The register file clears on the next edge. A read of the same register in the immediately following cycle (LATENCY=1) may return either value; this is acceptable.
- Snapshot (SNAP_EN=1):
  - A read of SNAP_IDX returns the live value and, at the same sampling edge, copies registers SNAP_IDX+1..SNAP_IDX+SNAP_LEN-1 into the buffer; SnapValid<=1.
  - While SnapValid=1, reads of those upper indices return buffered values, not live ones.
  - A read of SNAP_IDX+SNAP_LEN-1 clears SnapValid at its sampling edge.
  - Re-reading SNAP_IDX re-captures and overwrites the buffer.
  - With SnapValid=0, upper indices read live.
  - Snapshot registers obey CLR_MASK on their own reads; capture does not strobe RdClr.
- Idle: with no request, RdAck=0, RdClr=0, Hit=0, DataRd holds its last value.
- RdReq=1 with X on AddrReg is illegal; no protection is provided.

Test Plan:
- Defaults (NUM_REGS=32, LATENCY=1): reg_0E=0x5A, RdReq with AddrReg=0x0E -> next cycle RdAck=1, Hit=1, DataRd=0x5A, RdClr=0; following cycle RdAck=0, DataRd holds 0x5A.
- Out of range (BASE_ADDR=0x10, NUM_REGS=8, DEFAULT_DATA=0xFF): AddrReg=0x0F and AddrReg=0x18 -> each RdAck=1, Hit=0, DataRd=0xFF; AddrReg=0x17 -> Hit=1 with data of index 7.
- LATENCY=2, back-to-back RdReq on addresses 0x00, 0x01, 0x02 in consecutive cycles -> RdAck high in cycles 2, 3, 4 with data in order; PciReset pulsed low after the second request -> no further acks, all outputs 0.
- CLR_MASK bit 3 set, reg_03=0x80: read address 3 -> DataRd=0x80 with RdClr=0x0000_0008 only in the RdAck cycle; read address 4 -> RdClr=0.
- SNAP_EN=1, SNAP_IDX=4, SNAP_LEN=3, regs 4/5/6=0x11/0x22/0x33: read 4 -> SnapValid=1; change regs 5/6 to 0xAA/0xBB; read 5 then 6 -> 0x22 then 0x33, SnapValid=0 after the read of 6; read 5 again -> 0xAA.
